faultify_cut_sequencer: RTL and testbench

Sequencer that runs one fault-injection experiment on `circuit_under_test`. It loads the wide injection vector from 32-bit configuration writes and holds the CUT in reset before the run. It then feeds input samples one at a time through the CUT's sample_trig/filter_done handshake and compares each CUT output against a golden value. It sits between the AXI register bank / sample FIFOs and the CUT wrapper, and reports a mismatch count per run.

---
 rtl/faultify_cut_sequencer_if.sv | 41 ++++
 rtl/faultify_cut_sequencer.sv | 172 +++++++++++++++++
 tb/tb_faultify_cut_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/faultify_cut_sequencer_if.sv
// Signal bundle between the fault-injection sequencer (slave) and the register bank,
// sample FIFOs and CUT wrapper that surround it (master).
interface faultify_cut_sequencer_if #(
    parameter int INJ_WIDTH  = 346,
    parameter int DATA_WIDTH = 18
);
    logic                  cfg_wr_en;
    logic [3:0]            cfg_wr_addr;
    logic [31:0]           cfg_wr_data;
    logic                  run_start;
    logic                  run_abort;
    logic [15:0]           run_len;
    logic                  smp_valid;
    logic                  smp_ready;
    logic [DATA_WIDTH-1:0] smp_x;
    logic [DATA_WIDTH-1:0] smp_golden;
    logic                  cut_rst;
    logic [DATA_WIDTH:0]   test_vector;
    logic [DATA_WIDTH:0]   result_vector;
    logic [INJ_WIDTH-1:0]  injection_vector;
    logic                  busy;
    logic                  run_done;
    logic                  run_aborted;
    logic                  timeout_flag;
    logic [15:0]           err_count;
    logic [15:0]           smp_count;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, run_start, run_abort, run_len,
               smp_valid, smp_x, smp_golden, result_vector,
        input  smp_ready, cut_rst, test_vector, injection_vector, busy, run_done,
               run_aborted, timeout_flag, err_count, smp_count
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, run_start, run_abort, run_len,
               smp_valid, smp_x, smp_golden, result_vector,
        output smp_ready, cut_rst, test_vector, injection_vector, busy, run_done,
               run_aborted, timeout_flag, err_count, smp_count
    );
endinterface

// File: rtl/faultify_cut_sequencer.sv
// Runs one fault-injection experiment: loads the injection mask, resets the CUT, streams
// samples through the sample_trig/filter_done handshake and counts mismatches against golden.
module faultify_cut_sequencer #(
    parameter int INJ_WIDTH      = 346,
    parameter int DATA_WIDTH     = 18,
    parameter int TIMEOUT        = 64,
    parameter int CUT_RST_CYCLES = 2
) (
    input logic                     clk,
    input logic                     rst,
    faultify_cut_sequencer_if.slave bus
);
    localparam int NWORDS = (INJ_WIDTH + 31) / 32;
    localparam int TMR_W  = 16;

    // IDLE: wait start | CUTRST: hold CUT reset | WAIT_SMP: accept sample | TRIG: pulse trig | WAIT_DONE: await/compare | FINISH: pulse done
    typedef enum logic [2:0] {
        S_IDLE,
        S_CUTRST,
        S_WAIT_SMP,
        S_TRIG,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t                state;
    logic [TMR_W-1:0]      tmr;
    logic [15:0]           run_len_q;
    logic [DATA_WIDTH-1:0] golden_q;
    logic [INJ_WIDTH-1:0]  shadow;
    logic [INJ_WIDTH-1:0]  inj_q;
    logic [DATA_WIDTH:0]   tv_q;
    logic                  cut_rst_q;
    logic                  smp_ready_q;
    logic                  busy_q;
    logic                  run_done_q;
    logic                  aborted_q;
    logic                  tmo_q;
    logic [15:0]           err_q;
    logic [15:0]           cnt_q;
    logic                  done_in;
    logic                  match_in;

    assign done_in  = bus.result_vector[0];
    assign match_in = (bus.result_vector[DATA_WIDTH:1] == golden_q);

    // Bits beyond INJ_WIDTH in the last word have no storage and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (bus.cfg_wr_en && state == S_IDLE && int'(bus.cfg_wr_addr) < NWORDS) begin
            for (int b = 0; b < INJ_WIDTH; b++) begin
                if (int'(bus.cfg_wr_addr) == b / 32)
                    shadow[b] <= bus.cfg_wr_data[b % 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            tmr         <= '0;
            run_len_q   <= '0;
            golden_q    <= '0;
            inj_q       <= '0;
            tv_q        <= '0;
            cut_rst_q   <= 1'b0;
            smp_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
            aborted_q   <= 1'b0;
            tmo_q       <= 1'b0;
            err_q       <= '0;
            cnt_q       <= '0;
        end else begin
            run_done_q <= 1'b0;
            // Abort wins over a sample completing in the same cycle; counters stay frozen.
            if (bus.run_abort && state != S_IDLE && state != S_FINISH) begin
                state       <= S_FINISH;
                aborted_q   <= 1'b1;
                run_done_q  <= 1'b1;
                inj_q       <= '0;
                tv_q        <= '0;
                cut_rst_q   <= 1'b0;
                smp_ready_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.run_start && !bus.run_abort) begin
                            run_len_q <= bus.run_len;
                            err_q     <= '0;
                            cnt_q     <= '0;
                            tmo_q     <= 1'b0;
                            aborted_q <= 1'b0;
                            busy_q    <= 1'b1;
                            if (bus.run_len == 16'd0) begin
                                state      <= S_FINISH;
                                run_done_q <= 1'b1;
                            end else begin
                                state     <= S_CUTRST;
                                inj_q     <= shadow;
                                cut_rst_q <= 1'b1;
                                tmr       <= TMR_W'(CUT_RST_CYCLES - 1);
                            end
                        end
                    end
                    S_CUTRST: begin
                        if (tmr == '0) begin
                            state       <= S_WAIT_SMP;
                            cut_rst_q   <= 1'b0;
                            smp_ready_q <= 1'b1;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                    S_WAIT_SMP: begin
                        if (bus.smp_valid) begin
                            state       <= S_TRIG;
                            smp_ready_q <= 1'b0;
                            tv_q        <= {bus.smp_x, 1'b1};
                            golden_q    <= bus.smp_golden;
                        end
                    end
                    S_TRIG: begin
                        state   <= S_WAIT_DONE;
                        tv_q[0] <= 1'b0;
                        tmr     <= TMR_W'(TIMEOUT - 1);
                    end
                    S_WAIT_DONE: begin
                        if (done_in || tmr == '0) begin
                            if ((!done_in || !match_in) && err_q != 16'hFFFF)
                                err_q <= err_q + 16'd1;
                            if (!done_in)
                                tmo_q <= 1'b1;
                            cnt_q <= cnt_q + 16'd1;
                            if (cnt_q + 16'd1 == run_len_q) begin
                                state      <= S_FINISH;
                                run_done_q <= 1'b1;
                                inj_q      <= '0;
                                tv_q       <= '0;
                            end else begin
                                state       <= S_WAIT_SMP;
                                smp_ready_q <= 1'b1;
                            end
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                    S_FINISH: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.smp_ready        = smp_ready_q;
    assign bus.cut_rst          = cut_rst_q;
    assign bus.test_vector      = tv_q;
    assign bus.injection_vector = inj_q;
    assign bus.busy             = busy_q;
    assign bus.run_done         = run_done_q;
    assign bus.run_aborted      = aborted_q;
    assign bus.timeout_flag     = tmo_q;
    assign bus.err_count        = err_q;
    assign bus.smp_count        = cnt_q;
endmodule

// File: tb/tb_faultify_cut_sequencer.sv
// Self-checking bench for faultify_cut_sequencer: directed and randomized runs against a
// behavioural CUT and a count-based reference model.
module tb_faultify_cut_sequencer;
    localparam int INJ_W = 346;
    localparam int DW    = 18;
    localparam int NW    = (INJ_W + 31) / 32;
    localparam int TMO   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    faultify_cut_sequencer_if #(.INJ_WIDTH(INJ_W), .DATA_WIDTH(DW)) bus ();

    faultify_cut_sequencer #(
        .INJ_WIDTH(INJ_W), .DATA_WIDTH(DW), .TIMEOUT(TMO), .CUT_RST_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] xs[64];
    logic [DW-1:0] gs[64];
    bit            drop[64];
    int            lat[64];
    logic [31:0]   mdl_words[NW];

    // Behavioural CUT: echoes X lat[i] cycles after trig i, or never answers when drop[i].
    int            cut_idx = 0;
    int            cut_cd  = 0;
    logic [DW-1:0] cut_x   = '0;
    always @(negedge clk) begin
        if (rst || bus.cut_rst) begin
            cut_idx = 0;
            cut_cd  = 0;
            bus.result_vector = '0;
        end else begin
            bus.result_vector = '0;
            if (cut_cd > 0) begin
                cut_cd--;
                if (cut_cd == 0) bus.result_vector = {cut_x, 1'b1};
            end
            if (bus.test_vector[0]) begin
                cut_x  = bus.test_vector[DW:1];
                cut_cd = (cut_idx < 64 && !drop[cut_idx]) ? lat[cut_idx] : 0;
                cut_idx++;
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [INJ_W-1:0] ref_inj();
        logic [NW*32-1:0] flat;
        for (int k = 0; k < NW; k++) flat[k*32 +: 32] = mdl_words[k];
        return flat[INJ_W-1:0];
    endfunction

    function automatic int ref_errs(input int n);
        int e = 0;
        for (int i = 0; i < n; i++) if (drop[i] || gs[i] != xs[i]) e++;
        return e;
    endfunction

    function automatic bit ref_tmo(input int n);
        bit t = 0;
        for (int i = 0; i < n; i++) if (drop[i]) t = 1;
        return t;
    endfunction

    task automatic cfg_write(input int addr, input logic [31:0] data);
        @(negedge clk);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = 4'(addr);
        bus.cfg_wr_data = data;
        if (addr < NW) mdl_words[addr] = data;
        @(negedge clk);
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic set_samples(input int n, input int l, input bit dead);
        for (int i = 0; i < 64; i++) begin
            xs[i]   = DW'($urandom);
            gs[i]   = xs[i];
            drop[i] = dead;
            lat[i]  = l;
        end
    endtask

    int               r_cr_first, r_cr_last, r_ready_first, r_done_cycle, r_done_pulses;
    int               r_trigs, r_trig_wide, r_gap, r_abort_cycle;
    logic [INJ_W-1:0] r_inj1, r_inj_done;
    logic [15:0]      r_err, r_smp;
    logic             r_tmo, r_abt;
    bit               r_done_seen;

    task automatic do_run(input int len, input int abort_trig, input bit cfg_poke);
        int idx = 0;
        int c = 0;
        int tail = 0;
        int trig_cycle = -1;
        bit rdy_prev = 0, valid_prev = 0, trig_prev = 0, abort_sent = 0;
        r_cr_first = -1; r_cr_last = -1; r_ready_first = -1; r_done_cycle = -1;
        r_done_pulses = 0; r_trigs = 0; r_trig_wide = 0; r_gap = -1; r_abort_cycle = -1;
        r_done_seen = 0; r_inj1 = '0; r_inj_done = '1;
        r_err = 16'hDEAD; r_smp = 16'hDEAD; r_tmo = 1'bx; r_abt = 1'bx;
        @(negedge clk);
        bus.run_len   = 16'(len);
        bus.run_start = 1'b1;
        while (tail < 3 && c < 6000) begin
            @(negedge clk);
            c++;
            bus.run_start = 1'b0;
            bus.run_abort = 1'b0;
            bus.cfg_wr_en = 1'b0;
            if (rdy_prev && valid_prev) idx++;
            if (c == 1) r_inj1 = bus.injection_vector;
            if (bus.cut_rst) begin
                if (r_cr_first < 0) r_cr_first = c;
                r_cr_last = c;
            end
            if (bus.smp_ready && r_ready_first < 0) r_ready_first = c;
            if (bus.smp_ready && !rdy_prev && trig_cycle >= 0) r_gap = c - trig_cycle;
            if (bus.test_vector[0]) begin
                r_trigs++;
                if (trig_prev) r_trig_wide++;
                trig_cycle = c;
            end
            trig_prev = bus.test_vector[0];
            if (bus.run_done) begin
                r_done_pulses++;
                if (!r_done_seen) begin
                    r_done_seen  = 1;
                    r_done_cycle = c;
                    r_err        = bus.err_count;
                    r_smp        = bus.smp_count;
                    r_tmo        = bus.timeout_flag;
                    r_abt        = bus.run_aborted;
                    r_inj_done   = bus.injection_vector;
                end
            end
            if (r_done_seen) tail++;
            if (abort_trig > 0 && !abort_sent && r_trigs == abort_trig && !bus.test_vector[0]) begin
                bus.run_abort = 1'b1;
                abort_sent    = 1;
                r_abort_cycle = c;
            end
            if (cfg_poke && c == 5) begin
                bus.cfg_wr_en   = 1'b1;
                bus.cfg_wr_addr = 4'd0;
                bus.cfg_wr_data = ~mdl_words[0];
            end
            bus.smp_valid  = (idx < len);
            bus.smp_x      = xs[idx < 64 ? idx : 63];
            bus.smp_golden = gs[idx < 64 ? idx : 63];
            rdy_prev   = bus.smp_ready;
            valid_prev = bus.smp_valid;
        end
        bus.smp_valid = 1'b0;
        chk("run_done_seen", 512'(r_done_seen), 512'(1));
    endtask

    initial begin
        int len;
        bit seen;
        logic [31:0] w;
        bus.cfg_wr_en = 0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.run_start = 0; bus.run_abort = 0; bus.run_len = '0;
        bus.smp_valid = 0; bus.smp_x = '0; bus.smp_golden = '0;
        bus.result_vector = '0;
        for (int k = 0; k < NW; k++) mdl_words[k] = '0;
        set_samples(64, 5, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 512'(bus.busy), 512'(0));
        chk("rst_inj", 512'(bus.injection_vector), 512'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", 512'({bus.smp_ready, bus.cut_rst, bus.test_vector, bus.run_done,
                                  bus.run_aborted, bus.timeout_flag, bus.err_count, bus.smp_count}), 512'(0));

        // All-ones mask, one sample; out-of-range address must be dropped
        for (int k = 0; k < NW; k++) cfg_write(k, 32'hFFFF_FFFF);
        cfg_write(12, 32'h1234_5678);
        do_run(1, 0, 0);
        chk("ones_inj_run", 512'(r_inj1), 512'({INJ_W{1'b1}}));
        chk("ones_inj_ref", 512'(r_inj1), 512'(ref_inj()));
        chk("ones_inj_done", 512'(r_inj_done), 512'(0));
        chk("ones_cutrst_first", 512'(r_cr_first), 512'(1));
        chk("ones_cutrst_last", 512'(r_cr_last), 512'(2));
        chk("ones_ready_first", 512'(r_ready_first), 512'(3));
        chk("ones_smp", 512'(r_smp), 512'(1));
        chk("ones_err", 512'(r_err), 512'(0));
        chk("ones_inj_after", 512'(bus.injection_vector), 512'(0));
        chk("ones_busy_after", 512'(bus.busy), 512'(0));

        // Echo CUT, latency 5, matching golden
        set_samples(4, 5, 0);
        do_run(4, 0, 0);
        chk("echo_err", 512'(r_err), 512'(ref_errs(4)));
        chk("echo_smp", 512'(r_smp), 512'(4));
        chk("echo_done_pulses", 512'(r_done_pulses), 512'(1));
        chk("echo_trigs", 512'(r_trigs), 512'(4));
        chk("echo_trig_wide", 512'(r_trig_wide), 512'(0));

        // Same, golden[2] off by one
        gs[2] = xs[2] + DW'(1);
        do_run(4, 0, 0);
        chk("off1_err", 512'(r_err), 512'(ref_errs(4)));
        chk("off1_tmo", 512'(r_tmo), 512'(ref_tmo(4)));

        // Silent CUT: every sample times out
        set_samples(2, 5, 1);
        do_run(2, 0, 0);
        chk("dead_err", 512'(r_err), 512'(2));
        chk("dead_tmo", 512'(r_tmo), 512'(1));
        chk("dead_smp", 512'(r_smp), 512'(2));
        chk("dead_gap", 512'(r_gap), 512'(TMO + 1));

        // Randomized runs: random mask, latency, mismatches and dropped responses
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 14; k++) begin
                w = $urandom;
                cfg_write($urandom_range(0, 15), w);
            end
            len = $urandom_range(5, 20);
            for (int i = 0; i < 64; i++) begin
                xs[i]   = DW'($urandom);
                gs[i]   = ($urandom_range(0, 3) == 0) ? (xs[i] ^ DW'(1 << $urandom_range(0, DW - 1))) : xs[i];
                drop[i] = ($urandom_range(0, 7) == 0);
                lat[i]  = $urandom_range(1, 10);
            end
            do_run(len, 0, 0);
            chk("rnd_inj", 512'(r_inj1), 512'(ref_inj()));
            chk("rnd_err", 512'(r_err), 512'(ref_errs(len)));
            chk("rnd_smp", 512'(r_smp), 512'(len));
            chk("rnd_tmo", 512'(r_tmo), 512'(ref_tmo(len)));
            chk("rnd_trigs", 512'(r_trigs), 512'(len));
        end

        // Abort in WAIT_DONE of sample 3 of 10, with a cfg write attempted while busy
        set_samples(10, 5, 0);
        do_run(10, 3, 1);
        chk("abort_done_next", 512'(r_done_cycle), 512'(r_abort_cycle + 1));
        chk("abort_flag", 512'(r_abt), 512'(1));
        chk("abort_smp", 512'(r_smp), 512'(2));
        chk("abort_inj", 512'(r_inj_done), 512'(0));
        chk("abort_pulses", 512'(r_done_pulses), 512'(1));
        do_run(1, 0, 0);
        chk("abort_shadow_kept", 512'(r_inj1), 512'(ref_inj()));
        chk("abort_flag_cleared", 512'(r_abt), 512'(0));

        // run_start together with run_abort in IDLE does nothing
        @(negedge clk);
        bus.run_len = 16'd3; bus.run_start = 1'b1; bus.run_abort = 1'b1;
        @(negedge clk);
        bus.run_start = 1'b0; bus.run_abort = 1'b0;
        chk("idle_abort_busy", 512'(bus.busy), 512'(0));
        @(negedge clk);
        chk("idle_abort_nodone", 512'({bus.busy, bus.run_done, bus.cut_rst}), 512'(0));

        // Reset in the middle of WAIT_DONE
        set_samples(4, 8, 0);
        @(negedge clk);
        bus.run_len = 16'd4; bus.run_start = 1'b1;
        bus.smp_valid = 1'b1; bus.smp_x = xs[0]; bus.smp_golden = gs[0];
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            bus.run_start = 1'b0;
            if (bus.test_vector[0]) seen = 1;
        end
        chk("rst_trig_seen", 512'(seen), 512'(1));
        @(negedge clk);
        bus.smp_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_outputs", 512'({bus.busy, bus.smp_ready, bus.cut_rst, bus.test_vector, bus.run_done,
                                    bus.run_aborted, bus.timeout_flag, bus.err_count, bus.smp_count}), 512'(0));
        chk("rstmid_inj", 512'(bus.injection_vector), 512'(0));
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.run_done) seen = 1;
        end
        chk("rstmid_no_done", 512'(seen), 512'(0));
        rst = 1'b0;
        do_run(0, 0, 0);
        chk("len0_done_cycle", 512'(r_done_cycle), 512'(1));
        chk("len0_inj", 512'(r_inj1), 512'(0));
        chk("len0_no_cutrst", 512'(r_cr_first), 512'(-1));
        chk("len0_pulses", 512'(r_done_pulses), 512'(1));
        chk("len0_smp", 512'(r_smp), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
